// File: rtl/qsys_led_master_0_b2p_decoder_pkg.sv
// Shared definitions for the byte-stream <-> packet adapters on the JTAG master
// command/response path: framing characters and the decoder state encoding.
package qsys_led_master_0_b2p_decoder_pkg;

   // Framing characters; the p2b side encodes with these same values.
   localparam logic [7:0] B2P_SOP_CHAR  = 8'h7A;
   localparam logic [7:0] B2P_EOP_CHAR  = 8'h7B;
   localparam logic [7:0] B2P_CHAN_CHAR = 8'h7C;
   localparam logic [7:0] B2P_ESC_CHAR  = 8'h7D;
   localparam logic [7:0] B2P_ESC_XOR   = 8'h20;

   // Decoder states: NORM is the idle/payload state; the others remember the
   // prefix byte that changes how the next byte is interpreted.
   typedef enum logic [1:0] {
      NORM     = 2'd0,
      ESC      = 2'd1,
      CHAN     = 2'd2,
      CHAN_ESC = 2'd3
   } b2p_state_t;

endpackage

// File: rtl/qsys_led_master_0_b2p_decoder.sv
// Byte-stream-to-packet decoder: strips framing and escape characters from the
// host byte stream and emits Avalon-ST beats with SOP/EOP and channel through a
// one-deep registered output stage.
module qsys_led_master_0_b2p_decoder
   import qsys_led_master_0_b2p_decoder_pkg::*;
#(
   parameter int         CHANNEL_W = 8,
   parameter logic [7:0] SOP_CHAR  = B2P_SOP_CHAR,
   parameter logic [7:0] EOP_CHAR  = B2P_EOP_CHAR,
   parameter logic [7:0] CHAN_CHAR = B2P_CHAN_CHAR,
   parameter logic [7:0] ESC_CHAR  = B2P_ESC_CHAR
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 in_ready,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_startofpacket,
   output logic                 out_endofpacket,
   output logic [CHANNEL_W-1:0] out_channel
);

   b2p_state_t           state;
   logic                 sop_pend;
   logic                 eop_pend;
   logic [CHANNEL_W-1:0] cur_chan;
   logic                 accept;
   logic [7:0]           unesc;

   // The output register can take a new beat when it is empty or draining this cycle.
   assign in_ready = out_ready | ~out_valid;
   assign accept   = in_valid & in_ready;
   assign unesc    = in_data ^ B2P_ESC_XOR;

   // Decode FSM, pending framing flags and the registered output beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: every piece of state is reset here, so a partial packet in flight is
         // discarded and decoding restarts cleanly from NORM on the next byte.
         state             <= NORM;
         sop_pend          <= 1'b0;
         eop_pend          <= 1'b0;
         cur_chan          <= '0;
         out_valid         <= 1'b0;
         out_data          <= 8'h00;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_channel       <= '0;
      end else begin
         // NOTE: non-blocking assignments only; the drain below and a new beat
         // loaded further down in the same cycle resolve by last-assignment-wins.
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         if (accept) begin
            unique case (state)
               NORM: begin
                  if (in_data == SOP_CHAR)
                     sop_pend <= 1'b1;
                  else if (in_data == EOP_CHAR)
                     eop_pend <= 1'b1;
                  else if (in_data == CHAN_CHAR)
                     state <= CHAN;
                  else if (in_data == ESC_CHAR)
                     state <= ESC;
                  else begin
                     out_valid         <= 1'b1;
                     out_data          <= in_data;
                     out_startofpacket <= sop_pend;
                     out_endofpacket   <= eop_pend;
                     out_channel       <= cur_chan;
                     sop_pend          <= 1'b0;
                     eop_pend          <= 1'b0;
                  end
               end
               ESC: begin
                  // Escaped bytes are always payload, even if they decode to a special.
                  out_valid         <= 1'b1;
                  out_data          <= unesc;
                  out_startofpacket <= sop_pend;
                  out_endofpacket   <= eop_pend;
                  out_channel       <= cur_chan;
                  sop_pend          <= 1'b0;
                  eop_pend          <= 1'b0;
                  state             <= NORM;
               end
               CHAN: begin
                  if (in_data == ESC_CHAR)
                     state <= CHAN_ESC;
                  else begin
                     cur_chan <= in_data[CHANNEL_W-1:0];
                     state    <= NORM;
                  end
               end
               CHAN_ESC: begin
                  cur_chan <= unesc[CHANNEL_W-1:0];
                  state    <= NORM;
               end
               default: state <= NORM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qsys_led_master_0_b2p_decoder.sv
// Self-checking bench for the b2p decoder: directed byte streams, expected beats
// queued as stimulus is driven and compared as the DUT hands beats downstream.
// A second instance with CHANNEL_W=4 shares the stream to check channel truncation.
module tb_qsys_led_master_0_b2p_decoder;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [7:0] chan;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic [7:0] out_channel;

   logic       in_ready4;
   logic       out_valid4;
   logic [7:0] out_data4;
   logic       out_sop4;
   logic       out_eop4;
   logic [3:0] out_channel4;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   always #5 clk = ~clk;

   qsys_led_master_0_b2p_decoder dut (
      .clk               (clk),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_channel       (out_channel)
   );

   qsys_led_master_0_b2p_decoder #(.CHANNEL_W(4)) dut4 (
      .clk               (clk),
      .reset             (reset),
      .in_ready          (in_ready4),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .out_ready         (out_ready),
      .out_valid         (out_valid4),
      .out_data          (out_data4),
      .out_startofpacket (out_sop4),
      .out_endofpacket   (out_eop4),
      .out_channel       (out_channel4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic s, input logic e, input logic [7:0] c);
      beat_t b;
      b.data = d;
      b.sop  = s;
      b.eop  = e;
      b.chan = c;
      exp_q.push_back(b);
   endtask

   // Drive one byte and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [7:0] b);
      logic acc;
      int   n;
      in_valid = 1'b1;
      in_data  = b;
      n        = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until the output register is empty.
   task automatic wait_drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid && n < 50);
      check("drain", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare each beat as it is handed downstream.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", {24'd0, out_data},    {24'd0, e.data});
            check("beat_sop",  {31'd0, out_sop},     {31'd0, e.sop});
            check("beat_eop",  {31'd0, out_eop},     {31'd0, e.eop});
            check("beat_chan", {24'd0, out_channel}, {24'd0, e.chan});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid},   32'd0);
      check("rst_data",  {24'd0, out_data},    32'd0);
      check("rst_sop",   {31'd0, out_sop},     32'd0);
      check("rst_eop",   {31'd0, out_eop},     32'd0);
      check("rst_chan",  {24'd0, out_channel}, 32'd0);
      check("rst_ready", {31'd0, in_ready},    32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic packet on channel 3, back-to-back bytes.
      push(8'h11, 1'b1, 1'b0, 8'h03);
      push(8'h22, 1'b0, 1'b0, 8'h03);
      push(8'h33, 1'b0, 1'b1, 8'h03);
      send(8'h7A); send(8'h7C); send(8'h03);
      check("ctrl_no_beat", {31'd0, out_valid}, 32'd0);
      send(8'h11);
      check("latency", {31'd0, out_valid}, 32'd1);
      send(8'h22); send(8'h7B); send(8'h33);

      // Escaped specials are payload.
      push(8'h7A, 1'b1, 1'b0, 8'h03);
      push(8'h7D, 1'b0, 1'b1, 8'h03);
      send(8'h7A); send(8'h7D); send(8'h5A); send(8'h7B); send(8'h7D); send(8'h5D);

      // Escaped channel byte, single-beat packet.
      push(8'h44, 1'b1, 1'b1, 8'h7C);
      send(8'h7C); send(8'h7D); send(8'h5C); send(8'h7A); send(8'h7B); send(8'h44);

      // Repeated SOP, then a 5-cycle downstream stall.
      wait_drain();
      out_ready = 1'b0;
      push(8'h55, 1'b1, 1'b0, 8'h7C);
      push(8'h66, 1'b0, 1'b0, 8'h7C);
      send(8'h7A); send(8'h7A); send(8'h55);
      fork
         send(8'h66);
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", {31'd0, in_ready},  32'd0);
               check("stall_valid",    {31'd0, out_valid}, 32'd1);
               check("stall_data",     {24'd0, out_data},  32'h55);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join

      // Reset mid-packet drops SOP and channel.
      wait_drain();
      send(8'h7A); send(8'h7C); send(8'h05);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, out_valid},   32'd0);
      check("mid_rst_chan",  {24'd0, out_channel}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      push(8'h99, 1'b0, 1'b0, 8'h00);
      send(8'h99);

      // Channel truncation on the narrow instance.
      push(8'hAA, 1'b0, 1'b0, 8'hF7);
      send(8'h7C); send(8'hF7); send(8'hAA);
      check("w4_valid", {31'd0, out_valid4},   32'd1);
      check("w4_data",  {24'd0, out_data4},    32'hAA);
      check("w4_chan",  {28'd0, out_channel4}, 32'h7);

      wait_drain();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
